// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: synchronises and deglitches ps2c/ps2d, deframes 11-bit frames,
// filters E0/F0 sequences and holds each delivered make code until acknowledged.
module ps2_keyboard_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int DROP_BREAK     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       input_ack,
    output logic [7:0] keyboard_input_data,
    output logic       input_arrived_flag,
    output logic       frame_error,
    output logic       overrun
);
    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t         state;
    logic           c_s1, c_s2, d_s1, d_s2;
    logic           c_filt, d_filt, c_prev;
    logic [FCW-1:0] c_cnt, d_cnt;
    logic [2:0]     bitcnt;
    logic [7:0]     shift;
    logic           parity_ok;
    logic           break_pending;
    logic [TW-1:0]  tcnt;

    logic fall, accept_ok, deliver;

    // Synchronisers and glitch filters; presets model an idle (high) bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_s1   <= 1'b1;
            c_s2   <= 1'b1;
            d_s1   <= 1'b1;
            d_s2   <= 1'b1;
            c_filt <= 1'b1;
            d_filt <= 1'b1;
            c_prev <= 1'b1;
            c_cnt  <= '0;
            d_cnt  <= '0;
        end else begin
            c_s1   <= ps2c;
            c_s2   <= c_s1;
            d_s1   <= ps2d;
            d_s2   <= d_s1;
            c_prev <= c_filt;
            if (c_s2 != c_filt) begin
                if (c_cnt == FCW'(FILTER_LEN - 1)) begin
                    c_filt <= c_s2;
                    c_cnt  <= '0;
                end else begin
                    c_cnt <= c_cnt + 1'b1;
                end
            end else begin
                c_cnt <= '0;
            end
            if (d_s2 != d_filt) begin
                if (d_cnt == FCW'(FILTER_LEN - 1)) begin
                    d_filt <= d_s2;
                    d_cnt  <= '0;
                end else begin
                    d_cnt <= d_cnt + 1'b1;
                end
            end else begin
                d_cnt <= '0;
            end
        end
    end

    always_comb begin
        fall      = c_prev & ~c_filt;
        accept_ok = fall && (state == S_STOP) && d_filt && parity_ok;
        deliver   = accept_ok && (shift != 8'hE0) && !break_pending
                    && !((DROP_BREAK != 0) && (shift == 8'hF0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= S_IDLE;
            bitcnt              <= '0;
            shift               <= '0;
            parity_ok           <= 1'b0;
            break_pending       <= 1'b0;
            tcnt                <= '0;
            keyboard_input_data <= 8'h00;
            input_arrived_flag  <= 1'b0;
            frame_error         <= 1'b0;
            overrun             <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            overrun     <= 1'b0;

            if (fall) begin
                tcnt <= '0;
                case (state)
                    S_IDLE: begin
                        if (!d_filt) begin
                            state  <= S_DATA;
                            bitcnt <= '0;
                        end
                    end
                    S_DATA: begin
                        shift <= {d_filt, shift[7:1]};
                        if (bitcnt == 3'd7) state <= S_PARITY;
                        else bitcnt <= bitcnt + 1'b1;
                    end
                    S_PARITY: begin
                        parity_ok <= ^{shift, d_filt};
                        state     <= S_STOP;
                    end
                    default: begin
                        if (!(d_filt && parity_ok)) frame_error <= 1'b1;
                        state <= S_IDLE;
                    end
                endcase
            end else if (state != S_IDLE) begin
                // A stalled keyboard must not wedge the deframer.
                if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state       <= S_IDLE;
                    tcnt        <= '0;
                    frame_error <= 1'b1;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end

            if (accept_ok && shift != 8'hE0) begin
                if ((DROP_BREAK != 0) && shift == 8'hF0) break_pending <= 1'b1;
                else if (break_pending) break_pending <= 1'b0;
            end

            if (deliver) begin
                if (!input_arrived_flag || input_ack) begin
                    keyboard_input_data <= shift;
                    input_arrived_flag  <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (input_ack) begin
                input_arrived_flag <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Self-checking bench for ps2_keyboard_receiver: bit-level PS/2 frame driver,
// delivery scoreboard on an expected queue, error/overrun pulse monitors.
module tb_ps2_keyboard_receiver;
    localparam int FL   = 4;
    localparam int TO   = 200;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic       input_ack = 1'b0;
    logic [7:0] keyboard_input_data;
    logic       input_arrived_flag;
    logic       frame_error;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int fe_cyc = 0;
    int last_fall_cyc = 0;

    logic [7:0] exp_q[$];
    logic       prev_flag = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_fe = 1'b0;
    logic       prev_ov = 1'b0;

    ps2_keyboard_receiver #(
        .FILTER_LEN(FL),
        .TIMEOUT_CYCLES(TO),
        .DROP_BREAK(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ps2c(ps2c),
        .ps2d(ps2d),
        .input_ack(input_ack),
        .keyboard_input_data(keyboard_input_data),
        .input_arrived_flag(input_arrived_flag),
        .frame_error(frame_error),
        .overrun(overrun)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard and pulse monitors, sampled on the inactive edge
    always @(negedge clk) begin
        if (!reset) begin
            if (input_arrived_flag && (!prev_flag || keyboard_input_data != prev_data)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL delivery: unexpected byte %02h, none expected", keyboard_input_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (keyboard_input_data !== e) begin
                        errors++;
                        $display("FAIL delivery: got %02h expected %02h", keyboard_input_data, e);
                    end
                end
            end
            if (frame_error) begin
                fe_cnt++;
                fe_cyc = cyc;
                checks++;
                if (prev_fe) begin
                    errors++;
                    $display("FAIL frame_error_width: high %0d consecutive cycles, expected 1", 2);
                end
            end
            if (overrun) begin
                ov_cnt++;
                checks++;
                if (prev_ov) begin
                    errors++;
                    $display("FAIL overrun_width: high %0d consecutive cycles, expected 1", 2);
                end
            end
        end
        prev_flag = input_arrived_flag;
        prev_data = keyboard_input_data;
        prev_fe   = frame_error;
        prev_ov   = overrun;
    end

    // driver tasks
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bit,
                              input int nbits, input logic ack_on_stop);
        logic [10:0] bits;
        bits = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            wait_clk(HALF / 2);
            ps2d = bits[i];
            wait_clk(HALF / 2);
            ps2c = 1'b0;
            last_fall_cyc = cyc;
            if (i == 10 && ack_on_stop) begin
                // ack lands exactly on the accept edge of this stop bit
                wait_clk(FL + 2);
                input_ack = 1'b1;
                wait_clk(1);
                input_ack = 1'b0;
                wait_clk(HALF - FL - 3);
            end else begin
                wait_clk(HALF);
            end
            ps2c = 1'b1;
        end
        wait_clk(HALF / 2);
        ps2d = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic do_ack();
        input_ack = 1'b1;
        wait_clk(1);
        input_ack = 1'b0;
        wait_clk(2);
    endtask

    task automatic check_state(input string name, input logic [7:0] exp_data, input logic exp_flag);
        checks++;
        if (keyboard_input_data !== exp_data) begin
            errors++;
            $display("FAIL %s data: got %02h expected %02h", name, keyboard_input_data, exp_data);
        end
        checks++;
        if (input_arrived_flag !== exp_flag) begin
            errors++;
            $display("FAIL %s flag: got %0b expected %0b", name, input_arrived_flag, exp_flag);
        end
    endtask

    // scenarios
    task automatic test_reset();
        reset = 1'b1;
        wait_clk(5);
        check_state("reset", 8'h00, 1'b0);
        checks++;
        if (frame_error !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset pulses: frame_error=%0b overrun=%0b expected 0 0", frame_error, overrun);
        end
        reset = 1'b0;
        wait_clk(20);
    endtask

    task automatic test_single();
        int fe0, ov0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        check_state("single", 8'h1C, 1'b1);
        checks++;
        if (fe_cnt !== fe0 || ov_cnt !== ov0) begin
            errors++;
            $display("FAIL single pulses: fe=%0d ov=%0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
        end
        do_ack();
        check_state("single_ack", 8'h1C, 1'b0);
    endtask

    task automatic test_break();
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        do_ack();
        send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        check_state("break", 8'h1C, 1'b0);
        exp_q.push_back(8'h75);
        send_frame(8'hE0, 1'b0, 1'b1, 11, 1'b0);
        check_state("ext_prefix", 8'h1C, 1'b0);
        send_frame(8'h75, 1'b0, 1'b1, 11, 1'b0);
        check_state("extended", 8'h75, 1'b1);
        do_ack();
    endtask

    task automatic test_frame_errors();
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
        checks++;
        if (fe_cnt - fe0 !== 1) begin
            errors++;
            $display("FAIL parity_err count: got %0d expected 1", fe_cnt - fe0);
        end
        check_state("parity_err", 8'h75, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
        checks++;
        if (fe_cnt - fe0 !== 2) begin
            errors++;
            $display("FAIL stop_err count: got %0d expected 2", fe_cnt - fe0);
        end
        check_state("stop_err", 8'h75, 1'b0);
    endtask

    task automatic test_timeout();
        int fe0, dt;
        fe0 = fe_cnt;
        send_frame(8'h2A, 1'b0, 1'b1, 6, 1'b0);
        wait_clk(TO + 100);
        checks++;
        if (fe_cnt - fe0 !== 1) begin
            errors++;
            $display("FAIL timeout count: got %0d expected 1", fe_cnt - fe0);
        end
        // TO cycles after the fall is processed, which trails the raw edge by FL+3
        dt = fe_cyc - last_fall_cyc;
        checks++;
        if (dt < TO + FL + 1 || dt > TO + FL + 5) begin
            errors++;
            $display("FAIL timeout delay: got %0d cycles expected about %0d", dt, TO + FL + 3);
        end
        exp_q.push_back(8'h2A);
        send_frame(8'h2A, 1'b0, 1'b1, 11, 1'b0);
        check_state("after_timeout", 8'h2A, 1'b1);
        do_ack();
    endtask

    task automatic test_overrun();
        int ov0;
        ov0 = ov_cnt;
        exp_q.push_back(8'h15);
        send_frame(8'h15, 1'b0, 1'b1, 11, 1'b0);
        send_frame(8'h16, 1'b0, 1'b1, 11, 1'b0);
        check_state("overrun", 8'h15, 1'b1);
        checks++;
        if (ov_cnt - ov0 !== 1) begin
            errors++;
            $display("FAIL overrun count: got %0d expected 1", ov_cnt - ov0);
        end
        do_ack();
        ov0 = ov_cnt;
        exp_q.push_back(8'h15);
        exp_q.push_back(8'h16);
        send_frame(8'h15, 1'b0, 1'b1, 11, 1'b0);
        send_frame(8'h16, 1'b0, 1'b1, 11, 1'b1);
        check_state("ack_on_accept", 8'h16, 1'b1);
        checks++;
        if (ov_cnt !== ov0) begin
            errors++;
            $display("FAIL ack_on_accept overrun: got %0d pulses expected 0", ov_cnt - ov0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b1, 5, 1'b0);
        reset = 1'b1;
        wait_clk(10);
        check_state("mid_reset", 8'h00, 1'b0);
        checks++;
        if (frame_error !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset pulses: frame_error=%0b overrun=%0b expected 0 0", frame_error, overrun);
        end
        reset = 1'b0;
        wait_clk(TO + 50);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 1'b1, 11, 1'b0);
        check_state("after_reset", 8'h3C, 1'b1);
        checks++;
        if (fe_cnt !== fe0) begin
            errors++;
            $display("FAIL after_reset frame_error: got %0d pulses expected 0", fe_cnt - fe0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_break();
        test_frame_errors();
        test_timeout();
        test_overrun();
        test_reset_mid_frame();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d expected bytes never delivered, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
